// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: instruction-memory read port plus the decode-side valid/ready port.
interface fetch_queue_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rvalid, imem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential imem reads buffered with their PCs, flushed on a taken branch.
// Define FETCH_QUEUE_BYPASS_EN to forward a returning word straight to decode when the queue is empty.
module fetch_queue #(
  parameter int            DEPTH    = 4,
  parameter int            AW       = 8,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] PC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  fetch_queue_if.master          bus,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] inflight_pc;
  logic          inflight;
  logic          reset_q;

  logic          req;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          write;
  logic          head_valid;
  logic [DW-1:0] head_instr;
  logic [AW-1:0] head_pc;

  // Credit check counts the in-flight read, so a returning word always has a free slot.
  assign req  = !reset && !reset_q && !redirect && ((count + CW'(inflight)) < CW'(DEPTH));
  assign push = bus.imem_rvalid && inflight && !redirect && !reset;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    head_valid = 1'b0;
    head_instr = '0;
    head_pc    = '0;
    if (!reset) begin
      if (count != '0) begin
        head_valid = 1'b1;
        head_instr = instr_mem[rd_ptr];
        head_pc    = pc_mem[rd_ptr];
      end else if (bypass) begin
        head_valid = 1'b1;
        head_instr = bus.imem_rdata;
        head_pc    = inflight_pc;
      end
    end
  end

  // A bypassed word taken by decode never occupies a slot.
  assign pop   = (count != '0) && bus.out_ready && !reset;
  assign write = push && !(bypass && bus.out_ready);

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = head_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_q     <= 1'b1;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_pc    <= PC_RESET;
    end else begin
      reset_q <= 1'b0;
      if (redirect) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
        fetch_pc <= redirect_pc;
      end else begin
        inflight <= req;
        if (req) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + AW'(1);
        end
        if (write) wr_ptr <= wr_ptr + PW'(1);
        if (pop)   rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(write) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && (count == CW'(DEPTH))));
  end
endmodule
